wb_regfile_scoreboard: RTL

//  Write-back end of the MEM/WB interface: selects write data (mem vs ALU), writes the

---
 rtl/wb_regfile_scoreboard_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 44 ++++
 rtl/wb_regfile_scoreboard.sv | 69 ++++++
 3 files changed

// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared types and constants for the write-back register file and its scoreboard.
package wb_regfile_scoreboard_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register index at the default width; register 0 is the hardwired zero.
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;

  // True when an index names a real (writable) register.
  function automatic logic is_live(input reg_idx_t idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Single-bit busy scoreboard: set at issue, cleared at write-back, wiped by flush.
module wb_scoreboard
  import wb_regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy;

  // Busy vector update: flush wins, then issue set overrides a same-register WB clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      // NOTE: with non-blocking updates the last assignment to a bit in this block
      // wins, so ordering clear before set gives issue priority on a collision.
      if (wb_en && (wb_addr != '0)) busy[wb_addr] <= 1'b0;
      if (issue && (issue_addr != '0)) busy[issue_addr] <= 1'b1;
    end
  end

  // Stall lookup: a write-back this cycle satisfies the consumer through the bypass.
  always_comb begin
    rs_busy = (rs_addr != '0) && busy[rs_addr] && !(wb_en && (wb_addr == rs_addr));
    rt_busy = (rt_addr != '0) && busy[rt_addr] && !(wb_en && (wb_addr == rt_addr));
  end

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Write-back stage: data select, architectural register file with WB bypass, scoreboard.
module wb_regfile_scoreboard
  import wb_regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              regwrite_i,
  input  logic              memtoreg_i,
  input  logic [DATA_W-1:0] memdata_i,
  input  logic [DATA_W-1:0] aluresult_i,
  input  logic [ADDR_W-1:0] writeaddr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic [DATA_W-1:0] wb_data_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_live;

  // Write-back data select; also the forwarding source for earlier stages.
  always_comb begin
    wb_data_o = memtoreg_i ? memdata_i : aluresult_i;
    wr_live   = regwrite_i && (writeaddr_i != '0);
  end

  // Register file storage; register 0 is never written so it always reads zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the whole array is reset because architectural state must read zero
      // straight out of reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[writeaddr_i] <= wb_data_o;
    end
  end

  // Read ports with same-cycle write-through bypass.
  always_comb begin
    rs_data_o = (wr_live && (writeaddr_i == rs_addr_i)) ? wb_data_o : regs[rs_addr_i];
    rt_data_o = (wr_live && (writeaddr_i == rt_addr_i)) ? wb_data_o : regs[rt_addr_i];
  end

  wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .flush      (flush_i),
    .issue      (issue_i),
    .issue_addr (issue_addr_i),
    .wb_en      (regwrite_i),
    .wb_addr    (writeaddr_i),
    .rs_addr    (rs_addr_i),
    .rt_addr    (rt_addr_i),
    .rs_busy    (rs_busy_o),
    .rt_busy    (rt_busy_o)
  );

endmodule
